// File: rtl/ahb2obi_slave_adapter.sv
// AHB slave to OBI requester adapter: one transfer at a time, stretching
// the AHB data phase until the OBI response returns, with ERROR mapping.
module ahb2obi_slave_adapter #(
    parameter logic [31:0] P_ADDR_MASK = 32'hFFFF_FFFF,
    parameter int unsigned P_TIMEOUT   = 0
) (
    input  logic        hclk_i,
    input  logic        hresetn_i,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADYin,
    output logic [31:0] HRDATA,
    output logic        HREADYout,
    output logic [1:0]  HRESP,
    output logic        obi_req_o,
    input  logic        obi_gnt_i,
    output logic [31:0] obi_addr_o,
    output logic        obi_we_o,
    output logic [3:0]  obi_be_o,
    output logic [31:0] obi_wdata_o,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i,
    input  logic        obi_err_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RESP, S_DONE, S_ERR1, S_ERR2
    } state_t;

    localparam logic [31:0] TO_LAST =
        (P_TIMEOUT == 0) ? 32'd0 : 32'(P_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic        we_q;
    logic [2:0]  size_q;
    logic        stale_q;
    logic [31:0] cnt_q;
    logic [31:0] hrdata_q;
    logic        accept;
    logic        misaligned;
    logic        timeout;
    logic [3:0]  be;

    // Burst type and the BUSY/IDLE distinction carry no meaning here.
    logic unused_in;
    assign unused_in = ^{HBURST, HTRANS[0]};

    assign accept = HSEL & HREADYin & HTRANS[1] &
        (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR2);

    assign misaligned = (HSIZE > 3'd2) ||
        (HSIZE == 3'd1 && HADDR[0]) ||
        (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);

    assign timeout = (P_TIMEOUT != 0) && (cnt_q >= TO_LAST);

    assign HRDATA = hrdata_q;

    // Byte lanes derived from the captured size and low address bits
    always_comb begin
        be = 4'b1111;
        case (size_q)
            3'd0:    be = 4'b0001 << addr_q[1:0];
            3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        HREADYout   = 1'b1;
        HRESP       = 2'b00;
        obi_req_o   = 1'b0;
        obi_addr_o  = '0;
        obi_we_o    = 1'b0;
        obi_be_o    = '0;
        obi_wdata_o = '0;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR2: begin
                if (state_q == S_ERR2) HRESP = 2'b01;
                if (accept) state_d = misaligned ? S_ERR1 : S_REQ;
                else        state_d = S_IDLE;
            end
            S_REQ: begin
                HREADYout   = 1'b0;
                obi_req_o   = ~stale_q;
                obi_addr_o  = addr_q & P_ADDR_MASK;
                obi_we_o    = we_q;
                obi_be_o    = be;
                obi_wdata_o = HWDATA;
                if (obi_gnt_i && !stale_q) state_d = S_RESP;
                else if (timeout)          state_d = S_ERR1;
            end
            S_RESP: begin
                HREADYout = 1'b0;
                if (obi_rvalid_i) state_d = obi_err_i ? S_ERR1 : S_DONE;
                else if (timeout) state_d = S_ERR1;
            end
            S_ERR1: begin
                HREADYout = 1'b0;
                HRESP     = 2'b01;
                state_d   = S_ERR2;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, captured address phase, wait counter, stale flag, read data
    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            size_q   <= '0;
            stale_q  <= 1'b0;
            cnt_q    <= '0;
            hrdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= HADDR;
                we_q   <= HWRITE;
                size_q <= HSIZE;
            end
            if (state_d != state_q)
                cnt_q <= '0;
            else if (state_q == S_REQ || state_q == S_RESP)
                cnt_q <= cnt_q + 32'd1;
            if (state_q == S_RESP && !obi_rvalid_i && timeout)
                stale_q <= 1'b1;
            else if (stale_q && obi_rvalid_i)
                stale_q <= 1'b0;
            if (state_q == S_RESP && obi_rvalid_i && !obi_err_i && !we_q)
                hrdata_q <= obi_rdata_i;
        end
    end

endmodule

// File: tb/tb_ahb2obi_slave_adapter.sv
// Directed bench for ahb2obi_slave_adapter with a hand-driven OBI target.
// Mask 0xFFF, timeout 4 cycles.
module tb_ahb2obi_slave_adapter;

    logic        hclk_i = 1'b0;
    logic        hresetn_i;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADYin;
    logic [31:0] HRDATA;
    logic        HREADYout;
    logic [1:0]  HRESP;
    logic        obi_req_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;

    int total = 0;
    int bad   = 0;

    ahb2obi_slave_adapter #(
        .P_ADDR_MASK(32'h0000_0FFF),
        .P_TIMEOUT  (4)
    ) dut (
        .hclk_i      (hclk_i),
        .hresetn_i   (hresetn_i),
        .HSEL        (HSEL),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HWDATA      (HWDATA),
        .HREADYin    (HREADYin),
        .HRDATA      (HRDATA),
        .HREADYout   (HREADYout),
        .HRESP       (HRESP),
        .obi_req_o   (obi_req_o),
        .obi_gnt_i   (obi_gnt_i),
        .obi_addr_o  (obi_addr_o),
        .obi_we_o    (obi_we_o),
        .obi_be_o    (obi_be_o),
        .obi_wdata_o (obi_wdata_o),
        .obi_rvalid_i(obi_rvalid_i),
        .obi_rdata_i (obi_rdata_i),
        .obi_err_i   (obi_err_i)
    );

    always #5 hclk_i = ~hclk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge hclk_i);
        #1;
    endtask

    task automatic addr_phase(input logic w, input logic [2:0] sz,
                              input logic [31:0] a);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = w;
        HSIZE  = sz;
        HADDR  = a;
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
    endtask

    task automatic obi_quiet();
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b0;
        obi_err_i    = 1'b0;
    endtask

    initial begin
        hresetn_i   = 1'b0;
        HSEL        = 1'b0;
        HADDR       = '0;
        HTRANS      = 2'b00;
        HWRITE      = 1'b0;
        HSIZE       = 3'd0;
        HBURST      = 3'd0;
        HWDATA      = '0;
        HREADYin    = 1'b1;
        obi_rdata_i = '0;
        obi_quiet();
        #3;
        chk("rst_hready", 32'(HREADYout), 32'd1);
        chk("rst_hresp", 32'(HRESP), 32'd0);
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("rst_req", 32'(obi_req_o), 32'd0);
        chk("rst_obi", {obi_addr_o[27:0], obi_be_o}, 32'd0);
        chk("rst_we_wd", 32'(obi_we_o) | obi_wdata_o, 32'd0);
        cyc();
        hresetn_i = 1'b1;
        cyc();

        // Unselected NONSEQ: no access, zero wait
        HSEL = 1'b0; HTRANS = 2'b10; HADDR = 32'h40; HSIZE = 3'd2;
        cyc();
        bus_idle();
        #2;
        chk("unsel_req", 32'(obi_req_o), 32'd0);
        chk("unsel_ready", 32'(HREADYout), 32'd1);
        cyc();

        // Word read 0x40
        addr_phase(1'b0, 3'd2, 32'h40);
        cyc();
        bus_idle();
        obi_gnt_i = 1'b1;
        #2;
        chk("rd_req", 32'(obi_req_o), 32'd1);
        chk("rd_ready1", 32'(HREADYout), 32'd0);
        chk("rd_addr", obi_addr_o, 32'h40);
        chk("rd_be", 32'(obi_be_o), 32'hF);
        chk("rd_we", 32'(obi_we_o), 32'd0);
        cyc();
        obi_gnt_i = 1'b0;
        obi_rvalid_i = 1'b1;
        obi_rdata_i = 32'hDEAD_BEEF;
        #2;
        chk("rd_ready2", 32'(HREADYout), 32'd0);
        chk("rd_req2", 32'(obi_req_o), 32'd0);
        cyc();
        obi_quiet();
        #2;
        chk("rd_ready3", 32'(HREADYout), 32'd1);
        chk("rd_hresp", 32'(HRESP), 32'd0);
        chk("rd_hrdata", HRDATA, 32'hDEAD_BEEF);
        cyc();

        // Byte write 0x103
        addr_phase(1'b1, 3'd0, 32'hF000_0103);
        cyc();
        bus_idle();
        HWDATA = 32'hAA00_0000;
        obi_gnt_i = 1'b1;
        #2;
        chk("wr_req", 32'(obi_req_o), 32'd1);
        chk("wr_addr", obi_addr_o, 32'h103);
        chk("wr_be", 32'(obi_be_o), 32'h8);
        chk("wr_we", 32'(obi_we_o), 32'd1);
        chk("wr_wdata", obi_wdata_o, 32'hAA00_0000);
        cyc();
        obi_gnt_i = 1'b0;
        obi_rvalid_i = 1'b1;
        obi_rdata_i = 32'h0000_0055;
        cyc();
        obi_quiet();
        #2;
        chk("wr_ready", 32'(HREADYout), 32'd1);
        chk("wr_hresp", 32'(HRESP), 32'd0);
        chk("wr_hrdata_hold", HRDATA, 32'hDEAD_BEEF);
        cyc();

        // Misaligned half read 0x41
        addr_phase(1'b0, 3'd1, 32'h41);
        cyc();
        bus_idle();
        #2;
        chk("mis_req", 32'(obi_req_o), 32'd0);
        chk("mis_e1", {30'd0, HREADYout, HRESP[0]}, 32'b01);
        cyc();
        #2;
        chk("mis_e2", {30'd0, HREADYout, HRESP[0]}, 32'b11);
        chk("mis_req2", 32'(obi_req_o), 32'd0);
        cyc();
        #2;
        chk("mis_idle", {30'd0, HREADYout, HRESP[0]}, 32'b10);
        cyc();

        // OBI error response
        addr_phase(1'b0, 3'd2, 32'h44);
        cyc();
        bus_idle();
        obi_gnt_i = 1'b1;
        cyc();
        obi_gnt_i = 1'b0;
        obi_rvalid_i = 1'b1;
        obi_err_i = 1'b1;
        obi_rdata_i = 32'h0000_0BAD;
        cyc();
        obi_quiet();
        #2;
        chk("err_e1", {30'd0, HREADYout, HRESP[0]}, 32'b01);
        cyc();
        #2;
        chk("err_e2", {30'd0, HREADYout, HRESP[0]}, 32'b11);
        chk("err_hrdata", HRDATA, 32'hDEAD_BEEF);
        cyc();

        // Response timeout after 4 RESP cycles
        addr_phase(1'b0, 3'd2, 32'h48);
        cyc();
        bus_idle();
        obi_gnt_i = 1'b1;
        cyc();
        obi_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("to_wait%0d", i),
                {30'd0, HREADYout, HRESP[0]}, 32'b00);
            cyc();
        end
        #2;
        chk("to_e1", {30'd0, HREADYout, HRESP[0]}, 32'b01);
        cyc();
        #2;
        chk("to_e2", {30'd0, HREADYout, HRESP[0]}, 32'b11);
        cyc();

        // Next read while stale: req held off until late rvalid
        addr_phase(1'b0, 3'd2, 32'h4C);
        cyc();
        bus_idle();
        obi_rvalid_i = 1'b1;
        obi_rdata_i = 32'h0000_1234;
        #2;
        chk("stale_req", 32'(obi_req_o), 32'd0);
        chk("stale_ready", 32'(HREADYout), 32'd0);
        cyc();
        obi_rvalid_i = 1'b0;
        obi_gnt_i = 1'b1;
        #2;
        chk("stale_drop", HRDATA, 32'hDEAD_BEEF);
        chk("fresh_req", 32'(obi_req_o), 32'd1);
        chk("fresh_addr", obi_addr_o, 32'h4C);
        cyc();
        obi_gnt_i = 1'b0;
        obi_rvalid_i = 1'b1;
        obi_rdata_i = 32'hCAFE_F00D;
        cyc();
        obi_quiet();
        #2;
        chk("fresh_ready", 32'(HREADYout), 32'd1);
        chk("fresh_hrdata", HRDATA, 32'hCAFE_F00D);
        cyc();

        // Back-to-back reads, second accepted in DONE
        addr_phase(1'b0, 3'd2, 32'h50);
        cyc();
        bus_idle();
        obi_gnt_i = 1'b1;
        cyc();
        obi_gnt_i = 1'b0;
        obi_rvalid_i = 1'b1;
        obi_rdata_i = 32'h1111_1111;
        cyc();
        obi_quiet();
        addr_phase(1'b0, 3'd2, 32'h54);
        #2;
        chk("b2b_done", 32'(HREADYout), 32'd1);
        chk("b2b_hrdata", HRDATA, 32'h1111_1111);
        cyc();
        bus_idle();
        obi_gnt_i = 1'b1;
        #2;
        chk("b2b_req", 32'(obi_req_o), 32'd1);
        chk("b2b_addr", obi_addr_o, 32'h54);
        cyc();
        obi_gnt_i = 1'b0;
        #2;
        chk("b2b_resp", 32'(HREADYout), 32'd0);

        // Reset in RESP
        hresetn_i = 1'b0;
        #1;
        chk("mrst_ready", 32'(HREADYout), 32'd1);
        chk("mrst_req", 32'(obi_req_o), 32'd0);
        chk("mrst_hresp", 32'(HRESP), 32'd0);
        cyc();
        hresetn_i = 1'b1;
        obi_rvalid_i = 1'b1;
        obi_rdata_i = 32'h0000_0099;
        cyc();
        obi_quiet();
        #2;
        chk("mrst_late_rv", HRDATA, 32'd0);
        chk("mrst_ready2", 32'(HREADYout), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
